rr_arbiter_enc: RTL and testbench
=================================

// Module: rr_arbiter_enc
// PURPOSE
// - Round-robin arbiter sharing one resource among N requesters; emits one-hot grant plus its binary index.
// - The index comes from the 8-to-3 encoding function already used in the datapath.
// - Sits between request sources and the shared resource.
// - Grant is held while the winner keeps requesting, bounded by a hold limit.
// PARAMETERS
// - N         8   number of requesters (power of 2, >=2)
// - IDX_W     3   grant index width, $clog2(N)
// - MAX_HOLD  16  max consecutive grant cycles per winner; 0 = unlimited
// PORTS
// - clk        in   1      single clock, all logic on posedge
// - rst        in   1      synchronous, active-high reset
// - en         in   1      arbiter enable; 0 = no grant
// - req        in   N      request vector, held by requester until served
// - gnt        out  N      one-hot grant, registered
// - gnt_idx    out  IDX_W  binary index of gnt, registered
// - gnt_valid  out  1      1 when gnt != 0, registered
// BEHAVIOUR
// - Reset values (rst sampled high at posedge):
//   - gnt=0, gnt_idx=0, gnt_valid=0, hold_cnt=0, state=IDLE
//   - ptr=0 (ptr = highest-priority index for next arbitration)
// - States: IDLE (no grant), BUSY (grant to gnt_idx).
// - Arbitration function: first set bit of req scanning ptr, ptr+1, ... N-1, 0, ... ptr-1, modulo N.
// - IDLE:
//   - en=1 and |req -> next edge BUSY, grant winner; hold_cnt=1.
//   - Latency is 1 clk from req seen to gnt.
// - BUSY with grant to i; at each edge:
//   - en=0 -> IDLE, outputs cleared; ptr unchanged.
//   - req[i]=0 (release) -> ptr=i+1 mod N, then re-arbitrate in the same edge.
//     - Another req pending: grant it next cycle; no idle gap between grants.
//     - None pending: IDLE.
//   - MAX_HOLD!=0 and hold_cnt==MAX_HOLD with req[i]=1 -> forced release, handled as above.
//     - i is re-granted only if it is the sole requester; hold_cnt restarts at 1.
//   - Otherwise hold grant; hold_cnt++ (saturates, no wrap).
// - Arbitration always uses the updated ptr; only bits of req present at that edge are considered.
// - Requests arriving while BUSY wait; no request is dropped while req is held high.
// - Invariants:
//   - gnt always one-hot or zero.
//   - gnt_idx == encode(gnt); gnt_idx=0 when gnt=0.
//   - gnt_valid == |gnt.
// - Starvation bound: a held request is granted within (N-1)*MAX_HOLD+1 cycles when MAX_HOLD!=0.
// - Reset mid-grant: next edge returns to reset values; ptr=0.
// - No combinational path from req/en to outputs.
// STRUCTURE
// - Package arb_pkg:
//   - state encoding localparams ST_IDLE=1'b0, ST_BUSY=1'b1
//   - default N, MAX_HOLD
// - Sub-module prio_enc (combinational):
//   - in[N-1:0] -> idx[IDX_W-1:0], found; lowest set bit wins.
//   - Used on the rotated request (req rotated right by ptr); winner = (idx + ptr) mod N.
// - Top: FSM, ptr register, hold_cnt register, output registers.
// TESTING
// 1. Reset: assert rst 2 clks with req=8'hFF -> gnt=0, gnt_idx=0, gnt_valid=0 throughout.
// 2. Single request: en=1, req=8'b00000100 -> next clk gnt=8'b00000100, gnt_idx=3'd2, gnt_valid=1.
//    - Drop req -> next clk gnt=0.
// 3. Round robin: ptr=0, req=8'hFF, each winner releases after 1 cycle
//    - Grants in order idx 0,1,2,...,7,0 with no gap cycles.
// 4. Hold limit: MAX_HOLD=16, req=8'b10000001 held high
//    - idx 0 granted 16 clks, then idx 7 for 16 clks, then idx 0; idx never exceeds 16 consecutive cycles.
//    - Sole requester req=8'b00001000 -> idx 3 re-granted continuously, hold_cnt restarts.
// 5. Enable/reset mid-grant: gnt idx 5 active
//    - en=0 -> gnt=0 next clk, ptr unchanged; en=1 -> idx 5 regranted.
//    - rst=1 -> all outputs 0; after release, first arbitration starts at ptr=0.
// 6. Random: 10k cycles random req/en
//    - Scoreboard checks one-hot gnt, gnt_idx==encode(gnt), and the starvation bound.

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// arb_pkg : shared defaults and FSM encoding for the round-robin arbiter
// Rev 1.0
// ============================================================================
package arb_pkg;

    localparam int DEF_N        = 8;
    localparam int DEF_MAX_HOLD = 16;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_enc_prio_enc.sv
`default_nettype none
// ============================================================================
// prio_enc : lowest-set-bit priority encoder with found flag
// Rev 1.0
// ============================================================================
module prio_enc #(
    parameter int N     = 8,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     in,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (in[i]) begin
                idx   = i[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_enc.sv
`default_nettype none
// ============================================================================
// rr_arbiter_enc : round-robin arbiter, registered one-hot grant plus index
// Rev 1.0
// ============================================================================
module rr_arbiter_enc
    import arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int IDX_W    = $clog2(N),
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam int HOLD_W = (MAX_HOLD < 2) ? 2 : $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] C_HOLD_MAX = MAX_HOLD[HOLD_W-1:0];
    localparam logic [HOLD_W-1:0] C_HOLD_SAT = '1;
    localparam logic [N-1:0]      C_ONE      = {{(N-1){1'b0}}, 1'b1};

    state_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
    logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
    logic [N-1:0]       r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic               r_valid, w_valid_nxt;

    logic [IDX_W-1:0]   w_arb_ptr;
    logic [2*N-1:0]     w_dbl;
    logic [N-1:0]       w_rot;
    logic [IDX_W-1:0]   w_enc_idx;
    logic               w_found;
    logic [IDX_W-1:0]   w_win;
    logic               w_release;

    // While busy, arbitration only happens on release, where ptr becomes idx+1.
    assign w_arb_ptr = (r_state == S_BUSY) ? r_idx + 1'b1 : r_ptr;
    assign w_dbl     = {req, req} >> w_arb_ptr;
    assign w_rot     = w_dbl[N-1:0];
    assign w_win     = w_enc_idx + w_arb_ptr;
    assign w_release = !req[r_idx] || ((MAX_HOLD != 0) && (r_hold == C_HOLD_MAX));

    prio_enc #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .in    (w_rot),
        .idx   (w_enc_idx),
        .found (w_found)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold;
        w_gnt_nxt   = r_gnt;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        case (r_state)
            S_IDLE: begin
                if (en && w_found) begin
                    w_state_nxt = S_BUSY;
                    w_gnt_nxt   = C_ONE << w_win;
                    w_idx_nxt   = w_win;
                    w_valid_nxt = 1'b1;
                    w_hold_nxt  = {{(HOLD_W-1){1'b0}}, 1'b1};
                end
            end
            S_BUSY: begin
                if (!en) begin
                    w_state_nxt = S_IDLE;
                    w_gnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b0;
                    w_hold_nxt  = '0;
                end else if (w_release) begin
                    w_ptr_nxt = w_arb_ptr;
                    if (w_found) begin
                        w_gnt_nxt   = C_ONE << w_win;
                        w_idx_nxt   = w_win;
                        w_valid_nxt = 1'b1;
                        w_hold_nxt  = {{(HOLD_W-1){1'b0}}, 1'b1};
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_gnt_nxt   = '0;
                        w_idx_nxt   = '0;
                        w_valid_nxt = 1'b0;
                        w_hold_nxt  = '0;
                    end
                end else if (r_hold != C_HOLD_SAT) begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_hold  <= '0;
            r_gnt   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hold  <= w_hold_nxt;
            r_gnt   <= w_gnt_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign gnt_idx   = r_idx;
    assign gnt_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_enc.sv
`default_nettype none
// ============================================================================
// tb_rr_arbiter_enc : vector table, directed sequences and random run vs model
// Rev 1.0
// ============================================================================
module tb_rr_arbiter_enc;

    localparam int N        = 8;
    localparam int IDX_W    = 3;
    localparam int MAX_HOLD = 16;
    localparam int BOUND    = (N - 1) * MAX_HOLD + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b0;
    logic [N-1:0]     req = '0;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state: who holds the grant, for how long, and the scan start.
    bit m_busy;
    int m_idx, m_ptr, m_hold;
    int wait_cnt[N];

    typedef struct {
        logic             rst;
        logic             en;
        logic [N-1:0]     req;
        logic [N-1:0]     gnt;
        logic [IDX_W-1:0] idx;
        logic             valid;
    } vec_t;

    vec_t tbl[13];

    rr_arbiter_enc #(
        .N        (N),
        .IDX_W    (IDX_W),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] one;
        one = 1;
        return m_busy ? (one << m_idx) : '0;
    endfunction

    function automatic int encode(input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[k]) return k;
        return 0;
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_busy = 0; m_idx = 0; m_ptr = 0; m_hold = 0;
        end else if (!m_busy) begin
            if (en && req != '0) begin
                m_idx = pick(req, m_ptr); m_busy = 1; m_hold = 1;
            end
        end else if (!en) begin
            m_busy = 0; m_hold = 0;
        end else if (!req[m_idx] || m_hold == MAX_HOLD) begin
            m_ptr = (m_idx + 1) % N;
            if (req != '0) begin
                m_idx = pick(req, m_ptr); m_hold = 1;
            end else begin
                m_busy = 0; m_hold = 0;
            end
        end else begin
            m_hold++;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [N-1:0] q);
        @(negedge clk);
        rst = r; en = e; req = q;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    initial begin
        logic [N-1:0] nreq;
        logic [N-1:0] mask;
        logic         nrst, nen;
        int           worst, ex;

        tbl[0]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 3'd0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 8'hFF, 8'h00, 3'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 8'h04, 8'h04, 3'd2, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 8'h04, 8'h04, 3'd2, 1'b1};
        tbl[4]  = '{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 8'h21, 8'h20, 3'd5, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 8'h21, 8'h00, 3'd0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 8'h21, 8'h20, 3'd5, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 8'h21, 8'h00, 3'd0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 8'h21, 8'h01, 3'd0, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 8'h20, 8'h20, 3'd5, 1'b1};
        tbl[12] = '{1'b0, 1'b1, 8'h00, 8'h00, 3'd0, 1'b0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].req);
            chk($sformatf("tbl%0d_gnt", i),   gnt,       tbl[i].gnt);
            chk($sformatf("tbl%0d_idx", i),   gnt_idx,   tbl[i].idx);
            chk($sformatf("tbl%0d_valid", i), gnt_valid, tbl[i].valid);
        end

        // Round robin: each winner drops its request right after being granted.
        step(1'b1, 1'b0, '0);
        step(1'b0, 1'b1, 8'hFF);
        chk("rr_first_idx", gnt_idx, 0);
        for (int k = 1; k <= 8; k++) begin
            mask = 8'h01 << ((k - 1) % 8);
            step(1'b0, 1'b1, 8'hFF & ~mask);
            chk($sformatf("rr%0d_idx", k),   gnt_idx,   k % 8);
            chk($sformatf("rr%0d_valid", k), gnt_valid, 1);
        end

        // Hold limit alternation between idx 0 and idx 7.
        step(1'b1, 1'b0, '0);
        for (int c = 1; c <= 48; c++) begin
            step(1'b0, 1'b1, 8'h81);
            ex = (((c - 1) / MAX_HOLD) % 2 == 0) ? 0 : 7;
            chk($sformatf("hold%0d_idx", c),   gnt_idx,   ex);
            chk($sformatf("hold%0d_valid", c), gnt_valid, 1);
        end
        // Sole requester keeps the grant across hold-limit boundaries.
        for (int c = 1; c <= 40; c++) begin
            step(1'b0, 1'b1, 8'h08);
            chk($sformatf("sole%0d_gnt", c), gnt, 8'h08);
        end

        // Random run against the reference model.
        step(1'b1, 1'b0, '0);
        for (int k = 0; k < N; k++) wait_cnt[k] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            nreq = req;
            for (int k = 0; k < N; k++) begin
                if (req[k]) begin
                    if (m_busy && m_idx == k && $urandom_range(0, 2) == 0) nreq[k] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    nreq[k] = 1'b1;
                end
            end
            nen  = ($urandom_range(0, 31) != 0);
            nrst = ($urandom_range(0, 1999) == 0);
            step(nrst, nen, nreq);
            chk("rnd_gnt",    gnt,       exp_gnt());
            chk("rnd_idx",    gnt_idx,   m_busy ? m_idx : 0);
            chk("rnd_valid",  gnt_valid, m_busy);
            chk("rnd_onehot", $onehot0(gnt), 1);
            chk("rnd_enc",    gnt_idx,   encode(gnt));
            worst = 0;
            for (int k = 0; k < N; k++) begin
                if (rst || !en || !req[k] || gnt[k]) wait_cnt[k] = 0;
                else wait_cnt[k]++;
                if (wait_cnt[k] > worst) worst = wait_cnt[k];
            end
            vectors++;
            if (worst > BOUND) begin
                miscompares++;
                $display("FAIL starve: wait %0d exceeds limit %0d at t=%0t", worst, BOUND, $time);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
